// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage.
// Architectural addresses and interrupt FSM encoding.
package cpu_defs;

   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
   localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      TAKEN   = 2'd2
   } irq_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch and ROM.
// Fetch drives the address, ROM answers combinationally.
interface fetch_stage_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush, interrupt marker, write, hold.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        inject,
   input  logic        write,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        if_id_irq
);

   // Load bubble, marker or fetched word; otherwise hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_id_pc    <= 32'h0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         if_id_irq   <= 1'b0;
      end else if (flush) begin
         if_id_pc    <= pc;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         if_id_irq   <= 1'b0;
      end else if (inject) begin
         if_id_pc    <= pc;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b1;
         if_id_irq   <= 1'b1;
      end else if (write) begin
         if_id_pc    <= pc;
         if_id_instr <= instr;
         if_id_valid <= 1'b1;
         if_id_irq   <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID, interrupt
// injection and a saturating stall counter.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
   parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   fetch_stage_if.master    imem,
   input  logic [31:0]      next_pc,
   input  logic             pc_write,
   input  logic             if_id_write,
   input  logic             if_id_flush,
   input  logic             irq,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic             if_id_irq,
   output logic             irq_taken,
   output logic [CNT_W-1:0] stall_count
);

   import cpu_defs::*;

   irq_state_t state;
   logic       irq_q;
   logic       take;

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_addr = pc;

   // Marker goes in only on a clean advancing user-mode cycle.
   assign take = (state == PENDING) && pc_write && if_id_write &&
                 !if_id_flush && !pc[31];

   // PC register: load next_pc unless stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         pc <= RESET_PC;
      else if (pc_write) pc <= next_pc;
   end

   // Interrupt FSM with edge detect and registered take pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         irq_q     <= 1'b0;
         irq_taken <= 1'b0;
      end else begin
         irq_q     <= irq;
         irq_taken <= take;
         unique case (state)
            IDLE:
               if (irq && !irq_q && !pc[31]) state <= PENDING;
            PENDING:
               if (pc[31])    state <= IDLE;
               else if (take) state <= TAKEN;
            TAKEN:
               if (pc[31]) state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count <= '0;
      else if (!pc_write && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk         (clk),
      .reset       (reset),
      .flush       (if_id_flush),
      .inject      (take),
      .write       (if_id_write),
      .pc          (pc),
      .instr       (imem.imem_rdata),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .if_id_irq   (if_id_irq)
   );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
- Owns the PC register and the IF/ID pipeline register.
- Consumes the next-PC value chosen by the PC-source mux: PC+4, branch target, jump, jr, ILLOP 0x80000004 or XADR 0x80000008.
- Applies load-use stalls and branch/jump flushes, converts an external interrupt request into a marked IF/ID bubble for the decoder, and counts stall cycles.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset; bit 31 = kernel mode.
- NOP_INSTR, 32'h0000_0000, instruction word injected on flush or interrupt.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- next_pc  in  32  next PC from the PC-source mux.
- pc_write  in  1  1 = load next_pc into PC; 0 = stall (hold PC).
- if_id_write  in  1  1 = load IF/ID; 0 = hold IF/ID.
- if_id_flush  in  1  1 = load a bubble into IF/ID (branch taken, jump, exception).
- irq  in  1  level interrupt request, synchronous to clk.
- imem_rdata  in  32  instruction at imem_addr, combinational ROM read.
- imem_addr  out  32  equal to pc.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction or an interrupt marker.
- if_id_irq  out  1  IF/ID holds an interrupt marker; the decoder forces XADR and writes if_id_pc into $26.
- irq_taken  out  1  one-cycle pulse in the cycle the interrupt is injected.
- stall_count  out  CNT_W  count of cycles with pc_write = 0.

Behaviour:
- Reset, asynchronous, applies immediately: pc = RESET_PC; if_id_instr = NOP_INSTR; if_id_pc = 0; if_id_valid = 0; if_id_irq = 0; irq_taken = 0; stall_count = 0; FSM = IDLE; irq_q = 0.
- Reset deassertion mid-operation: the first fetch is from RESET_PC on the next edge. No state survives reset.
- PC register: on each rising edge, if pc_write = 1 then pc <= next_pc; otherwise pc holds. pc_plus4 is combinational.
- IF/ID register, priority order per edge:
  1. if_id_flush = 1 → NOP_INSTR, valid 0, irq 0, if_id_pc = pc. The flush overrides a stall, so flush with if_id_write = 0 still bubbles.
  2. Interrupt injection (see the FSM) → NOP_INSTR, valid 1, irq 1, if_id_pc = pc, which is the return address.
  3. if_id_write = 1 → imem_rdata, valid 1, irq 0, if_id_pc = pc.
  4. Otherwise hold.
- Fetch latency: an instruction at address A appears in IF/ID one edge after pc = A, unless a stall or flush intervenes.
- Interrupt FSM; irq_q is irq registered for rising-edge detection:
  - IDLE → PENDING when irq = 1, irq_q = 0 and pc[31] = 0. Requests arriving in kernel mode are ignored and not queued.
  - PENDING → TAKEN in a cycle with pc_write = 1, if_id_write = 1, if_id_flush = 0 and pc[31] = 0. That cycle injects the marker and irq_taken = 1.
  - PENDING holds through stalls and flushes; a flush in that cycle wins and injection retries.
  - PENDING → IDLE, without injecting, if pc[31] becomes 1 by another path (e.g. ILLOP).
  - TAKEN → IDLE once pc[31] = 1. No re-take while in TAKEN, even if irq is still high.
- Simultaneous irq rising edge and a pending-take condition: the request enters PENDING first. Injection occurs at the earliest on the following edge.
- stall_count increments when pc_write = 0 and saturates at all-ones. No wrap-around.

Decomposition:
- Shared package cpu_defs:
  - constants RESET_PC, ILLOP_ADDR = 32'h8000_0004, XADR_ADDR = 32'h8000_0008, NOP_INSTR;
  - interrupt FSM state encoding IDLE/PENDING/TAKEN (2 bits).
- One natural sub-module: if_id_reg, the IF/ID register with the flush/hold/inject priority mux.
- The PC register, FSM and counter stay in fetch_stage.

Test Plan:
- Reset, then pc_write = 1, if_id_write = 1, next_pc = pc_plus4, ROM word k = k → pc = 0x80000000, 0x80000004, ...; cycle after first edge: if_id_instr = 0, if_id_pc = 0x80000000, valid 1.
- Stall: pc_write = 0 and if_id_write = 0 for 3 cycles at pc = 0x00400010 → pc and IF/ID hold; stall_count = 3. Hold stall_count preloaded at 0xFFFF → stays 0xFFFF.
- Flush together with if_id_write = 0 at pc = 0x00400020 → IF/ID = NOP, valid 0, if_id_pc = 0x00400020; pc still follows pc_write.
- irq pulse at pc = 0x00400100, no stall → irq_taken pulses one edge later; IF/ID: irq 1, valid 1, pc 0x00400104. With next_pc = 0x80000008, the FSM returns to IDLE; irq still high produces no second take.
- irq rising while pc = 0x80000010 → no PENDING, irq_taken never pulses. irq arrives during a 2-cycle flush → injection is delayed until the first non-flush cycle.
- Assert reset while in PENDING with a stall active → all outputs return to reset values asynchronously; FSM = IDLE after release.
